// File: rtl/output_port_arbiter.sv
// output_port_arbiter
//   Shares one switch output link among PORTS_NUM neighbour inputs plus the
//   local core (PORTS_NUM+1 requesters) using wormhole locking. The winner
//   of a round-robin pick owns the link until its tail flit has been
//   accepted downstream and retired by the source.
//
// Ports
//   clk, a_rst      clock, synchronous active-high reset
//   wr_ready_in     per-source flit-valid
//   data_i          per-source flits, source i at [i*BUS_SIZE +: BUS_SIZE]
//   r_ready_out     per-source accept pulse (one-hot, owner only)
//   wr_ready_out    flit-valid toward the downstream link
//   data_o          registered flit toward the downstream link
//   r_ready_in      downstream accept
//   grant_o         one-hot current owner, 0 while unlocked
//   timeout_evt     one-cycle pulse on forced lock release
//
// Build option
//   ARB_TIMEOUT_EN  when defined, a lock whose owner presents no flit for
//                   TIMEOUT_CYCLES cycles in LOAD is released. Undefined:
//                   lock is held indefinitely and timeout_evt is tied 0.
module output_port_arbiter #(
  parameter int DATA_SIZE      = 32,
  parameter int ADDR_SIZE      = 4,
  parameter int PORTS_NUM      = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                                clk,
  input  logic                                                a_rst,
  input  logic [PORTS_NUM:0]                                  wr_ready_in,
  input  logic [(DATA_SIZE+ADDR_SIZE+1)*(PORTS_NUM+1)-1:0]    data_i,
  output logic [PORTS_NUM:0]                                  r_ready_out,
  output logic                                                wr_ready_out,
  output logic [DATA_SIZE+ADDR_SIZE:0]                        data_o,
  input  logic                                                r_ready_in,
  output logic [PORTS_NUM:0]                                  grant_o,
  output logic                                                timeout_evt
);
  localparam int BUS_SIZE = DATA_SIZE + ADDR_SIZE + 1;
  localparam int NREQ     = PORTS_NUM + 1;
  localparam int IW       = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, ACK} state_t;

  state_t              state;
  logic [IW-1:0]       last_grant;
  logic [IW-1:0]       g;
  logic [IW-1:0]       winner;
  logic                found;
  logic                tail;
  logic [BUS_SIZE-1:0] slice [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign slice[i] = data_i[i*BUS_SIZE +: BUS_SIZE];
  end

  // Round-robin pick: scan from last_grant+1 and wrap, so the previous
  // owner is considered last.
  always_comb begin
    logic [IW:0] idx;
    winner = last_grant;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = {1'b0, last_grant} + (IW+1)'(k);
      if (idx >= (IW+1)'(NREQ)) idx = idx - (IW+1)'(NREQ);
      if (!found && wr_ready_in[idx[IW-1:0]]) begin
        winner = idx[IW-1:0];
        found  = 1'b1;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] cnt;
`else
  assign timeout_evt = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (a_rst) begin
      state        <= IDLE;
      wr_ready_out <= 1'b0;
      r_ready_out  <= '0;
      data_o       <= '0;
      grant_o      <= '0;
      last_grant   <= IW'(PORTS_NUM);
      g            <= '0;
      tail         <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      timeout_evt  <= 1'b0;
      cnt          <= '0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout_evt <= 1'b0;
      // Counter only runs while waiting in LOAD; any other state rearms it.
      if (state != LOAD) cnt <= '0;
`endif
      case (state)
        IDLE: begin
          if (found) begin
            g       <= winner;
            grant_o <= NREQ'(1) << winner;
            state   <= LOAD;
          end
        end
        LOAD: begin
          // Other requesters are ignored: the lock belongs to g.
          if (wr_ready_in[g]) begin
            data_o       <= slice[g];
            wr_ready_out <= 1'b1;
            state        <= SEND;
          end
`ifdef ARB_TIMEOUT_EN
          else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            timeout_evt <= 1'b1;
            grant_o     <= '0;
            last_grant  <= g;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        SEND: begin
          if (r_ready_in) begin
            wr_ready_out <= 1'b0;
            r_ready_out  <= NREQ'(1) << g;
            tail         <= data_o[ADDR_SIZE];
            state        <= ACK;
          end
        end
        ACK: begin
          r_ready_out <= '0;
          // Wait for the source to retire the flit before the next one,
          // otherwise the same flit would be loaded twice.
          if (!wr_ready_in[g]) begin
            if (tail) begin
              last_grant <= g;
              grant_o    <= '0;
              state      <= IDLE;
            end else begin
              state <= LOAD;
            end
          end
        end
        default: begin
          state        <= IDLE;
          wr_ready_out <= 1'b0;
          r_ready_out  <= '0;
          data_o       <= '0;
          grant_o      <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_output_port_arbiter.sv
// Scoreboard bench for output_port_arbiter: stimulus pushes per-source flit
// queues plus the hand-ordered expected accept sequence; a monitor pops an
// expectation on every r_ready_out pulse.
module tb_output_port_arbiter;
  localparam int DATA_SIZE = 32;
  localparam int ADDR_SIZE = 4;
  localparam int PORTS_NUM = 4;
  localparam int TCYC      = 8;
  localparam int N         = PORTS_NUM + 1;
  localparam int BUS       = DATA_SIZE + ADDR_SIZE + 1;

  logic                 clk = 1'b0;
  logic                 a_rst = 1'b1;
  logic [N-1:0]         wr_ready_in;
  logic [BUS*N-1:0]     data_i;
  logic [N-1:0]         r_ready_out;
  logic                 wr_ready_out;
  logic [BUS-1:0]       data_o;
  logic                 r_ready_in = 1'b0;
  logic [N-1:0]         grant_o;
  logic                 timeout_evt;

  output_port_arbiter #(
    .DATA_SIZE(DATA_SIZE), .ADDR_SIZE(ADDR_SIZE),
    .PORTS_NUM(PORTS_NUM), .TIMEOUT_CYCLES(TCYC)
  ) dut (
    .clk(clk), .a_rst(a_rst), .wr_ready_in(wr_ready_in), .data_i(data_i),
    .r_ready_out(r_ready_out), .wr_ready_out(wr_ready_out), .data_o(data_o),
    .r_ready_in(r_ready_in), .grant_o(grant_o), .timeout_evt(timeout_evt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]     src;
    logic [BUS-1:0] flit;
  } exp_t;

  exp_t           exp_q [$];
  logic [BUS-1:0] srcq  [N][$];
  logic [BUS-1:0] din   [N];
  logic           req   [N];
  int             n_chk = 0;
  int             n_pass = 0;
  int             sink_delay = 1;
  bit             flush = 1'b0;
  int             pulses [N];
  bit             tevt_seen = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_src
    assign data_i[i*BUS +: BUS] = din[i];
    assign wr_ready_in[i]       = req[i];
  end

  function automatic logic [BUS-1:0] fl(logic [31:0] d, bit t, logic [3:0] a);
    return {d, t, a};
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic src_push(int s, logic [BUS-1:0] f);
    srcq[s].push_back(f);
  endtask

  task automatic exp_push(int s, logic [BUS-1:0] f);
    exp_t e;
    e.src  = 3'(s);
    e.flit = f;
    exp_q.push_back(e);
  endtask

  function automatic bit srcq_busy();
    for (int i = 0; i < N; i++) if (srcq[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Source model: present the queue head, retire it on its accept pulse.
  initial begin
    for (int i = 0; i < N; i++) begin req[i] = 1'b0; din[i] = '0; pulses[i] = 0; end
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (flush) begin
          srcq[i].delete();
          req[i] = 1'b0;
        end else if (r_ready_out[i[2:0]] && req[i]) begin
          req[i] = 1'b0;
          void'(srcq[i].pop_front());
        end else if (!req[i] && srcq[i].size() != 0) begin
          req[i] = 1'b1;
          din[i] = srcq[i][0];
        end
      end
    end
  end

  // Downstream sink: accept sink_delay cycles after valid appears.
  initial begin
    int c;
    c = 0;
    forever begin
      @(negedge clk);
      if (wr_ready_out && !r_ready_in) begin
        c++;
        if (c >= sink_delay) r_ready_in = 1'b1;
      end else begin
        r_ready_in = 1'b0;
        c = 0;
      end
    end
  end

  // Monitor: every accept pulse must match the next expected flit.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (timeout_evt) tevt_seen = 1'b1;
      if (r_ready_out != '0) begin
        for (int i = 0; i < N; i++) if (r_ready_out[i[2:0]]) pulses[i]++;
        if (exp_q.size() == 0) begin
          chk("unexpected_accept", 64'(r_ready_out), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("accept_port",  64'(r_ready_out), 64'(1) << e.src);
          chk("accept_flit",  64'(data_o),      64'(e.flit));
          chk("accept_grant", 64'(grant_o),     64'(1) << e.src);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(posedge clk); #1;
    a_rst = 1'b1; flush = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    a_rst = 1'b0; flush = 1'b0;
    exp_q.delete();
    for (int i = 0; i < N; i++) pulses[i] = 0;
  endtask

  task automatic check_idle(string nm);
    chk({nm, "_wr_ready_out"}, 64'(wr_ready_out), 64'd0);
    chk({nm, "_r_ready_out"},  64'(r_ready_out),  64'd0);
    chk({nm, "_data_o"},       64'(data_o),       64'd0);
    chk({nm, "_grant_o"},      64'(grant_o),      64'd0);
    chk({nm, "_timeout_evt"},  64'(timeout_evt),  64'd0);
  endtask

  task automatic drain(string nm, logic [N-1:0] hold);
    int k;
    int bad;
    bit busy;
    k = 0; bad = 0; busy = 1'b1;
    while (busy && k < 400) begin
      @(negedge clk);
      k++;
      if (hold != '0 && grant_o != '0 && grant_o != hold) bad++;
      busy = (exp_q.size() != 0) || srcq_busy();
    end
    repeat (3) @(negedge clk);
    chk({nm, "_complete"}, 64'(k < 400), 64'd1);
    chk({nm, "_released"}, 64'(grant_o), 64'd0);
    if (hold != '0) chk({nm, "_grant_hold"}, 64'(bad), 64'd0);
  endtask

  initial begin
    int k;
    logic [BUS-1:0] f;

    // Reset state
    do_reset();
    @(negedge clk);
    check_idle("reset");

    // Single source, 3-flit packet from source 2
    @(posedge clk); #1;
    src_push(2, fl(32'h1111_0001, 1'b0, 4'h2)); exp_push(2, fl(32'h1111_0001, 1'b0, 4'h2));
    src_push(2, fl(32'h1111_0002, 1'b0, 4'h2)); exp_push(2, fl(32'h1111_0002, 1'b0, 4'h2));
    src_push(2, fl(32'h1111_0003, 1'b1, 4'h2)); exp_push(2, fl(32'h1111_0003, 1'b1, 4'h2));
    drain("single", 5'b00100);
    chk("single_pulses", 64'(pulses[2]), 64'd3);
    chk("single_idle_valid", 64'(wr_ready_out), 64'd0);

    // Contention: sources 0, 1, 4 together from reset -> 0, 1, 4
    do_reset();
    src_push(0, fl(32'hA000_0000, 1'b0, 4'h1));
    src_push(0, fl(32'hA000_0001, 1'b1, 4'h1));
    src_push(1, fl(32'hB000_0000, 1'b1, 4'h2));
    src_push(4, fl(32'hC000_0000, 1'b0, 4'h3));
    src_push(4, fl(32'hC000_0001, 1'b1, 4'h3));
    exp_push(0, fl(32'hA000_0000, 1'b0, 4'h1));
    exp_push(0, fl(32'hA000_0001, 1'b1, 4'h1));
    exp_push(1, fl(32'hB000_0000, 1'b1, 4'h2));
    exp_push(4, fl(32'hC000_0000, 1'b0, 4'h3));
    exp_push(4, fl(32'hC000_0001, 1'b1, 4'h3));
    drain("contention", '0);

    // Fairness: source 0 keeps requesting, source 3 must slot in
    do_reset();
    src_push(0, fl(32'hD000_0000, 1'b0, 4'h5));
    src_push(0, fl(32'hD000_0001, 1'b1, 4'h5));
    src_push(0, fl(32'hD000_0002, 1'b1, 4'h5));
    src_push(3, fl(32'hE000_0000, 1'b1, 4'h6));
    exp_push(0, fl(32'hD000_0000, 1'b0, 4'h5));
    exp_push(0, fl(32'hD000_0001, 1'b1, 4'h5));
    exp_push(3, fl(32'hE000_0000, 1'b1, 4'h6));
    exp_push(0, fl(32'hD000_0002, 1'b1, 4'h5));
    drain("fairness", '0);

    // Backpressure: downstream silent for 10 cycles during SEND
    do_reset();
    sink_delay = 11;
    f = fl(32'hF00D_BEEF, 1'b1, 4'h7);
    src_push(1, f); exp_push(1, f);
    k = 0;
    while (!wr_ready_out && k < 50) begin @(negedge clk); k++; end
    chk("bp_valid_seen", 64'(k < 50), 64'd1);
    for (int c = 0; c < 10; c++) begin
      chk("bp_valid_held", 64'(wr_ready_out), 64'd1);
      chk("bp_data_held",  64'(data_o),       64'(f));
      chk("bp_no_accept",  64'(r_ready_out),  64'd0);
      @(negedge clk);
    end
    drain("backpressure", 5'b00010);
    sink_delay = 1;

    // Reset mid-packet after flit 1 of 3
    do_reset();
    src_push(2, fl(32'h7777_0001, 1'b0, 4'h8)); exp_push(2, fl(32'h7777_0001, 1'b0, 4'h8));
    src_push(2, fl(32'h7777_0002, 1'b0, 4'h8));
    src_push(2, fl(32'h7777_0003, 1'b1, 4'h8));
    k = 0;
    while (!r_ready_out[2] && k < 50) begin @(negedge clk); k++; end
    chk("midrst_first_flit", 64'(k < 50), 64'd1);
    @(posedge clk); #1;
    a_rst = 1'b1; flush = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_idle("midrst");
    @(posedge clk); #1;
    a_rst = 1'b0; flush = 1'b0;
    // Fresh search starts at source 0, so source 1 beats source 3
    src_push(1, fl(32'h8888_0001, 1'b1, 4'h9)); src_push(3, fl(32'h9999_0001, 1'b1, 4'hA));
    exp_push(1, fl(32'h8888_0001, 1'b1, 4'h9)); exp_push(3, fl(32'h9999_0001, 1'b1, 4'hA));
    drain("midrst_rearb", '0);

`ifdef ARB_TIMEOUT_EN
    // Source 1 sends a non-tail flit then goes quiet; source 2 is waiting
    do_reset();
    src_push(1, fl(32'h0BAD_0001, 1'b0, 4'hB)); exp_push(1, fl(32'h0BAD_0001, 1'b0, 4'hB));
    src_push(2, fl(32'h0C00_0001, 1'b1, 4'hC)); exp_push(2, fl(32'h0C00_0001, 1'b1, 4'hC));
    k = 0;
    while (!r_ready_out[1] && k < 50) begin @(negedge clk); k++; end
    chk("to_first_flit", 64'(k < 50), 64'd1);
    // ACK->LOAD lands one edge after the pulse; the pulse follows 8 LOAD cycles
    k = 0;
    do begin @(negedge clk); k++; end while (!timeout_evt && k < 40);
    chk("to_latency", 64'(k), 64'd9);
    chk("to_grant_released", 64'(grant_o), 64'd0);
    @(negedge clk);
    chk("to_pulse_width", 64'(timeout_evt), 64'd0);
    drain("to_next_grant", '0);
`else
    chk("no_timeout_evt", 64'(tevt_seen), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
